// File: rtl/emesh_pkg.sv
// Shared eMesh / AXI definitions for the eMesh-to-AXI bridge.
// Contents: eMesh packet field offsets and widths, the datamode enum, and the
// AXI constants used by the master write path.
package emesh_pkg;

   // eMesh packet layout
   localparam int unsigned PKT_W        = 104;
   localparam int unsigned PKT_WRITE    = 0;
   localparam int unsigned PKT_MODE_LSB = 1;
   localparam int unsigned PKT_MODE_W   = 2;
   localparam int unsigned PKT_CTRL_LSB = 3;
   localparam int unsigned PKT_CTRL_W   = 5;
   localparam int unsigned PKT_DST_LSB  = 8;
   localparam int unsigned PKT_DATA_LSB = 40;
   localparam int unsigned PKT_SRC_LSB  = 72;
   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_W       = 32;

   typedef enum logic [1:0] {
      DmByte   = 2'd0,
      DmHalf   = 2'd1,
      DmWord   = 2'd2,
      DmDouble = 2'd3
   } datamode_e;

   // AXI constants
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [3:0] AW_CACHE   = 4'b0011;
   localparam logic [2:0] AW_PROT    = 3'b000;
   localparam logic       AW_LOCK    = 1'b0;
   localparam logic [3:0] AW_QOS     = 4'b0000;

endpackage

// File: rtl/emesh_wr_lane.sv
// Byte-lane formatter: places a 32-bit eMesh value onto the 32-bit AXI data bus.
// Ports:
//   mode_i    datamode of the packet
//   addr_i    low two bits of the destination address
//   value_i   32-bit value from the packet
//   wdata_o   replicated write data
//   wstrb_o   byte strobes
//   awsize_o  AXI transfer size
module emesh_wr_lane
   import emesh_pkg::*;
(
   input  datamode_e   mode_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] value_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic [2:0]  awsize_o
);

   always_comb begin
      wdata_o  = value_i;
      wstrb_o  = 4'hF;
      awsize_o = 3'd2;
      case (mode_i)
         DmByte: begin
            wdata_o  = {4{value_i[7:0]}};
            wstrb_o  = 4'b0001 << addr_i;
            awsize_o = 3'd0;
         end
         DmHalf: begin
            wdata_o  = {2{value_i[15:0]}};
            wstrb_o  = 4'b0011 << {addr_i[1], 1'b0};
            awsize_o = 3'd1;
         end
         default: begin
            // word and doubleword beats use the full bus
            wdata_o  = value_i;
            wstrb_o  = 4'hF;
            awsize_o = 3'd2;
         end
      endcase
   end

endmodule

// File: rtl/emaxi_write.sv
// AXI4 master write engine: issues one eMesh write packet at a time as a single
// AXI write transaction (AW/W/B). Doubleword packets become a 2-beat INCR burst.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   wr_access, wr_packet   eMesh write request; wr_wait is backpressure
//   m_axi_aw*              AW channel (master)
//   m_axi_w*               W channel (master)
//   m_axi_b*               B channel (bid ignored)
//   wr_err                 sticky error, set by any non-OKAY response
module emaxi_write
   import emesh_pkg::*;
#(
   parameter logic [11:0] ID = 12'h000,
   parameter int unsigned PW = 104
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_access,
   input  logic [PW-1:0] wr_packet,
   output logic          wr_wait,
   output logic [11:0]   m_axi_awid,
   output logic [31:0]   m_axi_awaddr,
   output logic [7:0]    m_axi_awlen,
   output logic [2:0]    m_axi_awsize,
   output logic [1:0]    m_axi_awburst,
   output logic [3:0]    m_axi_awcache,
   output logic          m_axi_awlock,
   output logic [2:0]    m_axi_awprot,
   output logic [3:0]    m_axi_awqos,
   output logic          m_axi_awvalid,
   input  logic          m_axi_awready,
   output logic [11:0]   m_axi_wid,
   output logic [31:0]   m_axi_wdata,
   output logic [3:0]    m_axi_wstrb,
   output logic          m_axi_wlast,
   output logic          m_axi_wvalid,
   input  logic          m_axi_wready,
   input  logic [11:0]   m_axi_bid,
   input  logic [1:0]    m_axi_bresp,
   input  logic          m_axi_bvalid,
   output logic          m_axi_bready,
   output logic          wr_err
);

   typedef enum logic [1:0] {StIdle, StBusy, StWaitB} state_e;

   state_e      state_q, state_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        wr_wait_q, wr_wait_d;
   logic        wr_err_q, wr_err_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [7:0]  awlen_q, awlen_d;
   logic [2:0]  awsize_q, awsize_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        wlast_q, wlast_d;
   logic [31:0] src_q, src_d;

   datamode_e   pkt_mode;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_wstrb;
   logic [2:0]  lane_awsize;
   logic        aw_hs, w_hs, b_hs;
   logic        unused_bits;

   assign pkt_mode    = datamode_e'(wr_packet[PKT_MODE_LSB +: PKT_MODE_W]);
   // write bit, ctrlmode and bid carry no meaning for this engine
   assign unused_bits = ^{m_axi_bid, wr_packet[PKT_WRITE],
                          wr_packet[PKT_CTRL_LSB +: PKT_CTRL_W]};

   emesh_wr_lane u_lane (
      .mode_i   (pkt_mode),
      .addr_i   (wr_packet[PKT_DST_LSB +: 2]),
      .value_i  (wr_packet[PKT_DATA_LSB +: DATA_W]),
      .wdata_o  (lane_wdata),
      .wstrb_o  (lane_wstrb),
      .awsize_o (lane_awsize)
   );

   assign aw_hs = awvalid_q & m_axi_awready;
   assign w_hs  = wvalid_q & m_axi_wready;
   assign b_hs  = bready_q & m_axi_bvalid;

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      wr_err_d  = wr_err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      awsize_d  = awsize_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wlast_d   = wlast_q;
      src_d     = src_q;

      case (state_q)
         StIdle: begin
            if (wr_access && !wr_wait_q) begin
               awaddr_d  = wr_packet[PKT_DST_LSB +: ADDR_W];
               awsize_d  = lane_awsize;
               wdata_d   = lane_wdata;
               wstrb_d   = lane_wstrb;
               awlen_d   = (pkt_mode == DmDouble) ? 8'd1 : 8'd0;
               wlast_d   = (pkt_mode != DmDouble);
               src_d     = wr_packet[PKT_SRC_LSB +: ADDR_W];
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = StBusy;
            end
         end
         StBusy: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               if (wlast_q) begin
                  wvalid_d = 1'b0;
                  w_done_d = 1'b1;
               end else begin
                  // second doubleword beat carries srcaddr
                  wdata_d = src_q;
                  wstrb_d = 4'hF;
                  wlast_d = 1'b1;
               end
            end
            if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast_q))) begin
               bready_d = 1'b1;
               state_d  = StWaitB;
            end
         end
         StWaitB: begin
            if (b_hs) begin
               bready_d = 1'b0;
               if (m_axi_bresp != RESP_OKAY) begin
                  wr_err_d = 1'b1;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      wr_wait_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         wr_wait_q <= 1'b0;
         wr_err_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wlast_q   <= 1'b0;
         src_q     <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         wr_wait_q <= wr_wait_d;
         wr_err_q  <= wr_err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         awsize_q  <= awsize_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wlast_q   <= wlast_d;
         src_q     <= src_d;
      end
   end

   assign wr_wait       = wr_wait_q;
   assign wr_err        = wr_err_q;
   assign m_axi_awid    = ID;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = awsize_q;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awcache = AW_CACHE;
   assign m_axi_awlock  = AW_LOCK;
   assign m_axi_awprot  = AW_PROT;
   assign m_axi_awqos   = AW_QOS;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wid     = ID;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = wlast_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_emaxi_write.sv
// Directed bench for emaxi_write with hand-computed expectations.
module tb_emaxi_write;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_access;
   logic [103:0]  wr_packet;
   logic          wr_wait;
   logic [11:0]   awid;
   logic [31:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic [3:0]    awcache;
   logic          awlock;
   logic [2:0]    awprot;
   logic [3:0]    awqos;
   logic          awvalid;
   logic          awready;
   logic [11:0]   wid;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wlast;
   logic          wvalid;
   logic          wready;
   logic [11:0]   bid;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic          wr_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   emaxi_write dut (
      .clk           (clk),
      .rst           (rst),
      .wr_access     (wr_access),
      .wr_packet     (wr_packet),
      .wr_wait       (wr_wait),
      .m_axi_awid    (awid),
      .m_axi_awaddr  (awaddr),
      .m_axi_awlen   (awlen),
      .m_axi_awsize  (awsize),
      .m_axi_awburst (awburst),
      .m_axi_awcache (awcache),
      .m_axi_awlock  (awlock),
      .m_axi_awprot  (awprot),
      .m_axi_awqos   (awqos),
      .m_axi_awvalid (awvalid),
      .m_axi_awready (awready),
      .m_axi_wid     (wid),
      .m_axi_wdata   (wdata),
      .m_axi_wstrb   (wstrb),
      .m_axi_wlast   (wlast),
      .m_axi_wvalid  (wvalid),
      .m_axi_wready  (wready),
      .m_axi_bid     (bid),
      .m_axi_bresp   (bresp),
      .m_axi_bvalid  (bvalid),
      .m_axi_bready  (bready),
      .wr_err        (wr_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [103:0] mk_pkt(input logic [1:0] mode, input logic [31:0] dst,
                                           input logic [31:0] data, input logic [31:0] src);
      return {src, data, dst, 5'b0, mode, 1'b1};
   endfunction

   task automatic do_accept(input logic [103:0] p);
      @(negedge clk);
      wr_access = 1'b1;
      wr_packet = p;
      @(posedge clk);
      #1;
      wr_access = 1'b0;
   endtask

   // Single-beat write with all readies high and bvalid waiting.
   task automatic run_single(input string tag, input logic [103:0] p, input logic [31:0] e_addr,
                             input logic [2:0] e_size, input logic [3:0] e_strb,
                             input logic [31:0] e_data);
      do_accept(p);
      @(negedge clk);
      check_eq({tag, ".awvalid"}, 32'(awvalid), 32'd1);
      check_eq({tag, ".wvalid"}, 32'(wvalid), 32'd1);
      check_eq({tag, ".bready_busy"}, 32'(bready), 32'd0);
      check_eq({tag, ".wr_wait"}, 32'(wr_wait), 32'd1);
      check_eq({tag, ".awaddr"}, awaddr, e_addr);
      check_eq({tag, ".awsize"}, 32'(awsize), 32'(e_size));
      check_eq({tag, ".awlen"}, 32'(awlen), 32'd0);
      check_eq({tag, ".wstrb"}, 32'(wstrb), 32'(e_strb));
      check_eq({tag, ".wdata"}, wdata, e_data);
      check_eq({tag, ".wlast"}, 32'(wlast), 32'd1);
      @(negedge clk);
      check_eq({tag, ".bready"}, 32'(bready), 32'd1);
      check_eq({tag, ".awvalid_off"}, 32'(awvalid), 32'd0);
      check_eq({tag, ".wvalid_off"}, 32'(wvalid), 32'd0);
      @(negedge clk);
      check_eq({tag, ".wr_wait_done"}, 32'(wr_wait), 32'd0);
      check_eq({tag, ".bready_done"}, 32'(bready), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      wr_access = 1'b1;
      wr_packet = mk_pkt(2'd2, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0);
      awready   = 1'b1;
      wready    = 1'b1;
      bvalid    = 1'b1;
      bresp     = 2'b00;
      bid       = 12'h5A5;

      // reset state; wr_access ignored during reset
      repeat (3) @(negedge clk);
      check_eq("rst.awvalid", 32'(awvalid), 32'd0);
      check_eq("rst.wvalid", 32'(wvalid), 32'd0);
      check_eq("rst.bready", 32'(bready), 32'd0);
      check_eq("rst.wr_wait", 32'(wr_wait), 32'd0);
      check_eq("rst.wr_err", 32'(wr_err), 32'd0);
      check_eq("rst.awaddr", awaddr, 32'h0);
      check_eq("rst.wdata", wdata, 32'h0);
      check_eq("rst.wstrb", 32'(wstrb), 32'h0);
      check_eq("rst.wlast", 32'(wlast), 32'h0);
      check_eq("const.awburst", 32'(awburst), 32'h1);
      check_eq("const.awcache", 32'(awcache), 32'h3);
      check_eq("const.awprot", 32'(awprot), 32'h0);
      check_eq("const.awlock", 32'(awlock), 32'h0);
      check_eq("const.awqos", 32'(awqos), 32'h0);
      check_eq("const.awid", 32'(awid), 32'h0);
      check_eq("const.wid", 32'(wid), 32'h0);
      wr_access = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst.awvalid", 32'(awvalid), 32'd0);

      // word, byte, half
      run_single("word", mk_pkt(2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0),
                 32'h8000_0010, 3'd2, 4'hF, 32'hDEAD_BEEF);
      run_single("byte", mk_pkt(2'd0, 32'h4000_0003, 32'h0000_005A, 32'h0),
                 32'h4000_0003, 3'd0, 4'b1000, 32'h5A5A_5A5A);
      run_single("half", mk_pkt(2'd1, 32'h4000_0002, 32'h0000_1234, 32'h0),
                 32'h4000_0002, 3'd1, 4'b1100, 32'h1234_1234);
      run_single("half_lo", mk_pkt(2'd1, 32'h4000_0001, 32'hABCD_5678, 32'h0),
                 32'h4000_0001, 3'd1, 4'b0011, 32'h5678_5678);
      run_single("byte1", mk_pkt(2'd0, 32'h4000_0001, 32'h0000_00C3, 32'h0),
                 32'h4000_0001, 3'd0, 4'b0010, 32'hC3C3_C3C3);

      // doubleword burst
      do_accept(mk_pkt(2'd3, 32'h0000_0100, 32'h1111_1111, 32'h2222_2222));
      @(negedge clk);
      check_eq("dbl.awlen", 32'(awlen), 32'd1);
      check_eq("dbl.awsize", 32'(awsize), 32'd2);
      check_eq("dbl.beat0", wdata, 32'h1111_1111);
      check_eq("dbl.wlast0", 32'(wlast), 32'd0);
      check_eq("dbl.wstrb0", 32'(wstrb), 32'hF);
      @(negedge clk);
      check_eq("dbl.awvalid1", 32'(awvalid), 32'd0);
      check_eq("dbl.wvalid1", 32'(wvalid), 32'd1);
      check_eq("dbl.beat1", wdata, 32'h2222_2222);
      check_eq("dbl.wlast1", 32'(wlast), 32'd1);
      check_eq("dbl.wstrb1", 32'(wstrb), 32'hF);
      check_eq("dbl.bready1", 32'(bready), 32'd0);
      @(negedge clk);
      check_eq("dbl.bready", 32'(bready), 32'd1);
      check_eq("dbl.wvalid2", 32'(wvalid), 32'd0);
      @(negedge clk);
      check_eq("dbl.wr_wait", 32'(wr_wait), 32'd0);

      // AW stalled: W finishes first, second packet held off
      awready = 1'b0;
      do_accept(mk_pkt(2'd2, 32'hA000_0004, 32'hCAFE_F00D, 32'h0));
      @(negedge clk);
      check_eq("awstall.awvalid0", 32'(awvalid), 32'd1);
      wr_access = 1'b1;
      wr_packet = mk_pkt(2'd0, 32'hB000_0000, 32'h0000_0077, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("awstall.awvalid", 32'(awvalid), 32'd1);
         check_eq("awstall.awaddr", awaddr, 32'hA000_0004);
         check_eq("awstall.awsize", 32'(awsize), 32'd2);
         check_eq("awstall.wvalid", 32'(wvalid), 32'd0);
         check_eq("awstall.bready", 32'(bready), 32'd0);
         check_eq("awstall.wr_wait", 32'(wr_wait), 32'd1);
      end
      awready   = 1'b1;
      wr_access = 1'b0;
      @(negedge clk);
      check_eq("awstall.bready_on", 32'(bready), 32'd1);
      check_eq("awstall.awvalid_off", 32'(awvalid), 32'd0);
      @(negedge clk);
      check_eq("awstall.idle", 32'(wr_wait), 32'd0);
      @(negedge clk);
      check_eq("awstall.no_second", 32'(awvalid), 32'd0);

      // error response is sticky
      bresp = 2'b10;
      run_single("err", mk_pkt(2'd2, 32'h0000_0020, 32'h0BAD_0BAD, 32'h0),
                 32'h0000_0020, 3'd2, 4'hF, 32'h0BAD_0BAD);
      bresp = 2'b00;
      check_eq("err.set", 32'(wr_err), 32'd1);
      run_single("err_ok", mk_pkt(2'd2, 32'h0000_0024, 32'h0000_0001, 32'h0),
                 32'h0000_0024, 3'd2, 4'hF, 32'h0000_0001);
      check_eq("err.sticky", 32'(wr_err), 32'd1);

      // reset during BUSY drops valids asynchronously
      awready = 1'b0;
      wready  = 1'b0;
      do_accept(mk_pkt(2'd3, 32'h0000_0040, 32'h3333_3333, 32'h4444_4444));
      @(negedge clk);
      check_eq("rstbusy.awvalid_pre", 32'(awvalid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("rstbusy.awvalid", 32'(awvalid), 32'd0);
      check_eq("rstbusy.wvalid", 32'(wvalid), 32'd0);
      check_eq("rstbusy.bready", 32'(bready), 32'd0);
      check_eq("rstbusy.wr_err", 32'(wr_err), 32'd0);
      @(negedge clk);
      rst     = 1'b0;
      awready = 1'b1;
      wready  = 1'b1;
      check_eq("rstbusy.wr_wait", 32'(wr_wait), 32'd0);
      run_single("after_rst", mk_pkt(2'd0, 32'h0000_0052, 32'h0000_00E1, 32'h0),
                 32'h0000_0052, 3'd0, 4'b0100, 32'hE1E1_E1E1);

      // reset during WAIT_B drops bready asynchronously; early bvalid ignored
      bvalid = 1'b0;
      do_accept(mk_pkt(2'd2, 32'h0000_0060, 32'h5555_5555, 32'h0));
      @(negedge clk);
      @(negedge clk);
      check_eq("rstwb.bready_pre", 32'(bready), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("rstwb.bready", 32'(bready), 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      bvalid = 1'b1;
      @(negedge clk);
      check_eq("rstwb.idle", 32'(wr_wait), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/emaxi_write.md
# emaxi_write

AXI4 master write engine for the eMesh-to-AXI bridge: the initiator counterpart to the `esaxi` slave write path. It accepts one 104-bit eMesh write packet at a time and issues it as a single AXI write transaction on the AW, W and B channels. Doubleword packets go out as a 2-beat INCR burst on the 32-bit bus. The block sits between the eMesh write-request port and the external AXI interconnect.

## Interface
- `ID`, 12'h000: constant driven on `m_axi_awid` and `m_axi_wid`.
- `PW`, 104: eMesh packet width; fixed, and the only supported value.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_access` in 1: packet valid.
- `wr_packet` in 104: fields are [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
- `wr_wait` out 1: backpressure; a packet is accepted only when `wr_access && !wr_wait`.
- `m_axi_awid` out 12, `m_axi_awaddr` out 32, `m_axi_awlen` out 8, `m_axi_awsize` out 3, `m_axi_awburst` out 2: AW payload.
- `m_axi_awcache` out 4, `m_axi_awlock` out 1, `m_axi_awprot` out 3, `m_axi_awqos` out 4: constants 4'b0011, 0, 3'b000, 0.
- `m_axi_awvalid` out 1, `m_axi_awready` in 1: AW handshake.
- `m_axi_wid` out 12, `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wlast` out 1: W payload.
- `m_axi_wvalid` out 1, `m_axi_wready` in 1: W handshake.
- `m_axi_bid` in 12, `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: B channel.
- `wr_err` out 1: sticky flag, set by any B response with `bresp != 2'b00`.

## Operation
- States: IDLE, BUSY, WAIT_B.
- `wr_wait` is registered and equals `state != IDLE`.
- **IDLE:**
  - On acceptance, latch the packet.
  - Set `awvalid=1` and `wvalid=1`.
  - Clear the `aw_done` flag and the beat counter; go to BUSY.
- **BUSY:**
  - The AW and W channels are independent, and either may complete first.
  - `awvalid` drops on the cycle after `awvalid && awready`; that handshake sets `aw_done`.
  - Each `wvalid && wready` advances the beat.
  - After the last beat, `wvalid` drops.
  - When `aw_done` is set and the last beat is done (including completions in the same cycle), go to WAIT_B with `bready=1`.
- **WAIT_B:** on `bvalid && bready`, deassert `bready` and go to IDLE. `m_axi_bid` is ignored.
- **Formatting**, where `a = dstaddr[1:0]`:
  - Byte (datamode 0): awsize 0, wstrb `4'b0001<<a`, wdata `{4{data[7:0]}}`.
  - Half (datamode 1): awsize 1, wstrb `4'b0011<<{a[1],1'b0}`, wdata `{2{data[15:0]}}`.
  - Word (datamode 2): awsize 2, wstrb 4'hF, wdata = data.
  - Doubleword (datamode 3): awsize 2, awlen 1, beat0 = data, beat1 = srcaddr, wstrb 4'hF on both beats.
  - All other datamodes use awlen 0.
  - `awaddr = dstaddr`; `awburst = 2'b01` (INCR).
  - `wlast` is asserted on the final beat only.
- Accepted packets are always treated as writes; packet bit [0] and ctrlmode are not interpreted.

## Timing
- **Reset values:** state IDLE; all valids 0, `bready` 0, `wr_wait` 0, `wr_err` 0, all payload registers 0.
- While `rst` is high, `wr_access` is ignored.
- **Reset mid-operation:** all valids and `bready` drop asynchronously, and any in-flight transaction is abandoned.
- **Latency:** `awvalid` and `wvalid` first rise 1 cycle after acceptance.
- **Minimum per-packet period,** with slave ready always high and `bvalid` the cycle after:
  - Single-beat: 3 cycles.
  - Doubleword: 4 cycles.
- **AXI stability:** payload and valid are held stable while valid is high and ready is low; valid never drops before its handshake.
- **Early response:** `bvalid` arriving before WAIT_B is not acknowledged, because `bready` stays 0 until then.
- **Error flag:** `wr_err` sets the cycle after the erroring B handshake and clears only on reset.

## Structure
- Shared package `emesh_pkg` holds:
  - packet field offsets and widths;
  - the datamode enum (BYTE/HALF/WORD/DOUBLE);
  - AXI constants BURST_INCR, RESP_OKAY, and the AW cache/prot defaults.
- Sub-module `emesh_wr_lane` (combinational): maps datamode, address low bits and the 32-bit value to `wdata`/`wstrb`/`awsize`. It is shared with future read-response packing.

## Test plan
- Word write, dstaddr 0x8000_0010, data 0xDEADBEEF, readies high → awaddr 0x80000010, awsize 2, awlen 0, wstrb F, wlast 1; `wr_wait` low again 3 cycles after acceptance.
- Byte write, dstaddr 0x...03, data 0x5A → wstrb 4'b1000, wdata 0x5A5A5A5A; half write at 0x...02, data 0x1234 → wstrb 4'b1100, wdata 0x12341234.
- Doubleword, data 0x11111111, srcaddr 0x22222222 → awlen 1, beat0 0x11111111 with wlast 0, beat1 0x22222222 with wlast 1.
- awready held low 5 cycles while wready is high → W completes first, awvalid and payload stay stable, WAIT_B entered only after AW completes, no second packet accepted meanwhile.
- bresp 2'b10 → `wr_err` rises and stays high across subsequent OKAY transactions until `rst`.
- `rst` pulsed during BUSY → awvalid, wvalid and bready go to 0 immediately; the next packet after reset issues cleanly.
